// File: rtl/mem_latency_probe.sv
// mem_latency_probe: drives addresses into a memory under test and measures how many
// cycles pass before the read data matches the expected pattern; last/min/max/timeouts.
`default_nettype none

module mem_latency_probe #(
  parameter int              ADDR_W  = 7,
  parameter int              DATA_W  = 4,
  parameter int              CNT_W   = 8,
  parameter int              TIMEOUT = 200,
  parameter logic [DATA_W-1:0] EXP_XOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  lat_last,
  output logic [CNT_W-1:0]  lat_min,
  output logic [CNT_W-1:0]  lat_max,
  output logic [ADDR_W:0]   err_count
);

  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   STEP_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   STEP_ALL  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W:0]    steps;
  logic               match;

  assign match = (mem_data == (mem_addr[DATA_W-1:0] ^ EXP_XOR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_addr    <= '0;
      cnt         <= '0;
      steps       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      lat_last    <= '0;
      lat_min     <= '1;
      lat_max     <= '0;
      err_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr    <= mem_addr + ADDR_ONE;
            cnt         <= '0;
            steps       <= mode ? STEP_ALL : STEP_ONE;
            timeout_err <= 1'b0;
            err_count   <= '0;
            lat_min     <= '1;
            lat_max     <= '0;
            busy        <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (match || (cnt == TIMEOUT_C)) begin
            // A match in the same cycle as the timeout still counts as a match.
            if (match) begin
              lat_last <= cnt;
              lat_min  <= (cnt < lat_min) ? cnt : lat_min;
              lat_max  <= (cnt > lat_max) ? cnt : lat_max;
            end else begin
              lat_last    <= TIMEOUT_C;
              timeout_err <= 1'b1;
              err_count   <= err_count + STEP_ONE;
            end
            steps <= steps - STEP_ONE;
            if (steps > STEP_ONE) begin
              mem_addr <= mem_addr + ADDR_ONE;
              cnt      <= '0;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
